// File: rtl/timer_nbit_v2_pkg.sv
// Shared types for the n-bit timer v2: FSM states, control and flag bundles.
package timer_nbit_v2_pkg;

    localparam int TMR2_MAX_CH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr2_state_e;

    typedef struct packed {
        logic start;
        logic stop;
        logic cnt_clr;
        logic ld;
        logic one_shot;
        logic running;
    } tmr2_ctrl_t;

    typedef struct packed {
        logic                   ovf;
        logic [TMR2_MAX_CH-1:0] match;
    } tmr2_flags_t;

endpackage

// File: rtl/timer_nbit_v2_if.sv
// Decoded SFR fields into the timer and status back out for readback.
interface timer_nbit_v2_if #(
    parameter int N      = 32,
    parameter int NUM_CH = 4,
    parameter int PSC_W  = 8
);
    logic                start;
    logic                stop;
    logic                cnt_clr;
    logic                ld;
    logic [N-1:0]        ld_val;
    logic                one_shot;
    logic [PSC_W-1:0]    psc_div;
    logic [N-1:0]        period;
    logic [NUM_CH*N-1:0] match_val;
    logic [NUM_CH:0]     irq_en;
    logic [NUM_CH:0]     flag_clr;
    logic [N-1:0]        cnt_val;
    logic                running;
    logic [NUM_CH-1:0]   match_flag;
    logic                ovf_flag;
    logic [NUM_CH-1:0]   match_pulse;
    logic                ovf_pulse;
    logic [NUM_CH-1:0]   pwm_out;
    logic                irq;

    modport master (
        output start, stop, cnt_clr, ld, ld_val, one_shot,
        output psc_div, period, match_val, irq_en, flag_clr,
        input  cnt_val, running, match_flag, ovf_flag,
        input  match_pulse, ovf_pulse, pwm_out, irq
    );

    modport slave (
        input  start, stop, cnt_clr, ld, ld_val, one_shot,
        input  psc_div, period, match_val, irq_en, flag_clr,
        output cnt_val, running, match_flag, ovf_flag,
        output match_pulse, ovf_pulse, pwm_out, irq
    );
endinterface

// File: rtl/timer_nbit_v2_cmp.sv
// One compare channel: equality pulse after a tick, sticky W1C flag, PWM.
module tmr_compare_ch #(
    parameter int N = 32
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         sys_clk_en,
    input  logic         adv_q,
    input  logic         running,
    input  logic [N-1:0] cnt,
    input  logic [N-1:0] match_val,
    input  logic         flag_clr,
    output logic         match_pulse,
    output logic         match_flag,
    output logic         pwm
);

    // adv_q marks that cnt was produced by a tick, so ld/clr never match
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            match_pulse <= 1'b0;
            match_flag  <= 1'b0;
            pwm         <= 1'b0;
        end else if (sys_clk_en) begin
            match_pulse <= adv_q && (cnt == match_val);
            match_flag  <= match_pulse | (match_flag & ~flag_clr);
            pwm         <= running && (cnt < match_val);
        end
    end

endmodule

// File: rtl/timer_nbit_v2.sv
// Prescaled up-counter with auto-reload, one-shot mode, compare channels and irq.
import timer_nbit_v2_pkg::*;

module timer_nbit_v2 #(
    parameter int N      = 32,
    parameter int NUM_CH = 4,
    parameter int PSC_W  = 8
) (
    input logic           sys_clk,
    input logic           sys_rst,
    input logic           sys_clk_en,
    timer_nbit_v2_if.slave bus
);

    tmr2_state_e       state;
    tmr2_ctrl_t        ctrl;
    logic [PSC_W-1:0]  psc;
    logic [N-1:0]      cnt;
    logic              adv_q;
    logic              ovf_pend;
    logic              ovf_pulse;
    logic              ovf_flag;
    logic [NUM_CH-1:0] match_flag;
    logic              done;
    logic              run_en;
    logic              tick;
    logic              adv;
    logic              wrap;

    assign ctrl.start    = bus.start;
    assign ctrl.stop     = bus.stop;
    assign ctrl.cnt_clr  = bus.cnt_clr;
    assign ctrl.ld       = bus.ld;
    assign ctrl.one_shot = bus.one_shot;
    assign ctrl.running  = (state == RUN);

    // One-shot: hold the counter at 0 until the overflow pulse ends RUN
    always_comb begin
        done   = ctrl.one_shot && ovf_pend;
        run_en = ctrl.running && !done;
        tick   = run_en && (psc == bus.psc_div);
        adv    = tick && !ctrl.cnt_clr && !ctrl.ld;
        wrap   = adv && ((cnt == bus.period) || (cnt == {N{1'b1}}));
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            psc       <= '0;
            cnt       <= '0;
            adv_q     <= 1'b0;
            ovf_pend  <= 1'b0;
            ovf_pulse <= 1'b0;
            ovf_flag  <= 1'b0;
        end else if (sys_clk_en) begin
            unique case (state)
                IDLE: if (ctrl.start && !ctrl.stop) state <= RUN;
                RUN:  if (ctrl.stop || done) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (ctrl.cnt_clr || ctrl.ld || !run_en || tick)
                psc <= '0;
            else
                psc <= psc + 1'b1;

            if (ctrl.cnt_clr)
                cnt <= '0;
            else if (ctrl.ld)
                cnt <= bus.ld_val;
            else if (wrap)
                cnt <= '0;
            else if (adv)
                cnt <= cnt + 1'b1;

            adv_q     <= adv;
            ovf_pend  <= wrap;
            ovf_pulse <= ovf_pend;
            ovf_flag  <= ovf_pulse | (ovf_flag & ~bus.flag_clr[NUM_CH]);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tmr_compare_ch #(.N(N)) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .sys_clk_en  (sys_clk_en),
            .adv_q       (adv_q),
            .running     (ctrl.running),
            .cnt         (cnt),
            .match_val   (bus.match_val[i*N +: N]),
            .flag_clr    (bus.flag_clr[i]),
            .match_pulse (bus.match_pulse[i]),
            .match_flag  (match_flag[i]),
            .pwm         (bus.pwm_out[i])
        );
    end

    assign bus.cnt_val    = cnt;
    assign bus.running    = ctrl.running;
    assign bus.ovf_pulse  = ovf_pulse;
    assign bus.ovf_flag   = ovf_flag;
    assign bus.match_flag = match_flag;
    assign bus.irq        = |({ovf_flag, match_flag} & bus.irq_en);

endmodule

// File: doc/timer_nbit_v2.md
Name: timer_nbit_v2

Overview:
- Parametrised successor to the single-channel n-bit timer.
- Up-counter with prescaler, auto-reload period, continuous or one-shot mode, NUM_CH compare channels, and sticky W1C event flags.
- Provides per-channel PWM outputs and one combined interrupt.
- Sits behind the SFR block: control and config come in as decoded fields; counter/flag values go out for readback.

Parameters:
- N, 32, counter/period/compare width (2..32)
- NUM_CH, 4, number of compare channels (1..8)
- PSC_W, 8, prescaler divider width

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous active-high reset
- sys_clk_en  in  1  qualifies every sequential update; when 0, all state holds
- start  in  1  pulse: start counting
- stop  in  1  pulse: stop counting
- cnt_clr  in  1  pulse: counter and prescaler to 0
- ld  in  1  pulse: load counter from ld_val
- ld_val  in  N  load value
- one_shot  in  1  1 = stop after the first period wrap
- psc_div  in  PSC_W  tick every psc_div+1 enabled clocks
- period  in  N  wrap value
- match_val  in  NUM_CH*N  compare values, channel i at bits [i*N +: N]
- irq_en  in  NUM_CH+1  interrupt enables, bit NUM_CH = overflow
- flag_clr  in  NUM_CH+1  W1C pulse per flag
- cnt_val  out  N  current counter value
- running  out  1  1 while in RUN
- match_flag  out  NUM_CH  sticky match flags
- ovf_flag  out  1  sticky overflow flag
- match_pulse  out  NUM_CH  1-cycle match event
- ovf_pulse  out  1  1-cycle wrap event
- pwm_out  out  NUM_CH  PWM outputs
- irq  out  1  combined interrupt

Behaviour:
- Reset: all outputs 0; FSM = IDLE; prescaler = 0; counter = 0.
- FSM states: IDLE, RUN.
  - IDLE->RUN on start & !stop.
  - RUN->IDLE on stop (stop wins over start).
  - RUN->IDLE on a wrap when one_shot=1.
  - start while in RUN: no effect.
- Prescaler:
  - In RUN, counts 0..psc_div; tick asserts on the cycle prescaler == psc_div, and prescaler returns to 0.
  - psc_div = 0 gives a tick every enabled cycle.
  - Prescaler is held at 0 in IDLE.
- Counter update priority per enabled cycle: cnt_clr > ld > tick.
  - On tick: if cnt == period then cnt <= 0 and ovf_pulse = 1, else cnt <= cnt + 1. N-bit arithmetic.
  - If period = 0, every tick wraps.
- Loads above period:
  - The counter climbs to 2^N-1, wraps to 0, and ovf_pulse fires at that natural wrap.
  - This is the only case where an all-ones wrap occurs.
- cnt_clr and ld also clear the prescaler. Both are legal in either state; neither changes the FSM state.
- match_pulse[i]:
  - Registered. Asserts for one cycle in the cycle after the counter becomes equal to match_val[i] through a tick.
  - Does not fire on ld, cnt_clr, or reset.
- ovf_pulse: registered, same timing as match_pulse.
- One-shot completion: the counter is left at 0, and running drops in the same cycle ovf_pulse asserts.
- Flags:
  - Set by the corresponding pulse; cleared by flag_clr.
  - If set and clear occur in the same cycle, set wins.
- irq = |({ovf_flag, match_flag} & irq_en), combinational from the flag registers.
- pwm_out[i]:
  - Registered, 1 while running && cnt < match_val[i].
  - match_val[i] = 0 gives a constant 0.
  - match_val[i] > period gives a constant 1 while running.
  - 0 in IDLE.
- Config changes (period, match_val, psc_div) take effect immediately at the next comparison; there is no shadowing.
- sys_clk_en = 0: nothing advances, including pulses and flag clears; outputs hold.
- Reset asserted mid-run returns immediately to the reset state.

Decomposition:
- pkg_sfrs_definition gains:
  - tmr2_ctrl_t: start, stop, cnt_clr, ld, one_shot, running.
  - tmr2_flags_t.
  - tmr2_state_e: IDLE, RUN.
- Sub-module tmr_compare_ch: per-channel equality detect, match pulse, sticky flag, PWM. Instantiated NUM_CH times in a generate loop.

Test Plan:
- N=8, psc_div=0, period=9, continuous, start → cnt 0..9,0; ovf_pulse one cycle after cnt returns to 0; ovf_flag stays 1 until flag_clr[NUM_CH].
- psc_div=3, period=2 → counter advances every 4 cycles; wrap every 12 cycles after start.
- one_shot=1, period=5 → single ovf_pulse; running falls the same cycle; cnt=0; a second start repeats the sequence.
- match_val[0]=3, period=7 → match_pulse[0] one cycle per period; pwm_out[0] high 3 of 8 ticks. Then set match_val[1]=0 and match_val[2]=9 → pwm_out[1] constant 0, pwm_out[2] constant 1 while running.
- Same-cycle events:
  - ld=1, ld_val=3 together with cnt_clr → cnt=0.
  - start & stop together in IDLE → stays IDLE.
  - flag_clr on the same cycle as match_pulse → flag remains 1.
- sys_rst asserted mid-count at cnt=4 → all outputs 0 asynchronously. Separately, sys_clk_en=0 for 5 cycles → cnt and prescaler frozen.
